// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - MIPS32 control decode with a one-entry valid/ready output register
module ctrl_decode_stage #(
    parameter int TAG_W         = 32,
    parameter bit ENABLE_CP0    = 1'b1,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic             clk,        // rising-edge clock
    input  logic             rst,        // async active-high reset
    input  logic             in_valid,   // upstream instruction valid
    output logic             in_ready,   // stage can accept this cycle
    input  logic [31:0]      inst,       // instruction word
    input  logic [TAG_W-1:0] pc_in,      // PC tag travelling with inst
    input  logic             flush,      // drop held and incoming instruction
    output logic             out_valid,  // registered bundle valid
    input  logic             out_ready,  // downstream accepts
    output logic [TAG_W-1:0] pc_out,     // registered PC tag
    output logic [14:0]      ctrl,       // registered control bundle
    output logic [2:0]       exc         // registered {invalid, syscall, brk}
);

    localparam int B_REGWRITE = 14;
    localparam int B_REGDST   = 13;
    localparam int B_ALUSRC   = 12;
    localparam int B_BRANCH   = 11;
    localparam int B_MEMWRITE = 10;
    localparam int B_MEMTOREG = 9;
    localparam int B_JUMP     = 8;
    localparam int B_JUMPR    = 7;
    localparam int B_LINK     = 6;
    localparam int B_CP0WRITE = 5;
    localparam int B_HILO     = 4;
    localparam int B_ERET     = 3;
    localparam int B_MEMSIGN  = 0;

    localparam int E_INVALID  = 2;
    localparam int E_SYSCALL  = 1;
    localparam int E_BRK      = 0;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_inst_bits;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign funct = inst[5:0];
    // rd, shamt and immediate fields are consumed by later stages only
    assign unused_inst_bits = ^inst[15:6];

    logic [14:0] dec_ctrl;
    logic [2:0]  dec_exc;

    always_comb begin
        dec_ctrl = '0;
        dec_exc  = '0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        dec_ctrl[B_REGWRITE] = 1'b1;
                        dec_ctrl[B_REGDST]   = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        if (ENABLE_MULDIV) begin
                            dec_ctrl[B_REGWRITE] = 1'b1;
                            dec_ctrl[B_REGDST]   = 1'b1;
                        end else begin
                            dec_exc[E_INVALID] = 1'b1;
                        end
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (ENABLE_MULDIV) dec_ctrl[B_HILO] = 1'b1;
                        else               dec_exc[E_INVALID] = 1'b1;
                    end
                    6'h08: dec_ctrl[B_JUMPR] = 1'b1;
                    6'h09: begin
                        dec_ctrl[B_REGWRITE] = 1'b1;
                        dec_ctrl[B_REGDST]   = 1'b1;
                        dec_ctrl[B_JUMPR]    = 1'b1;
                        dec_ctrl[B_LINK]     = 1'b1;
                    end
                    6'h0c:   dec_exc[E_SYSCALL] = 1'b1;
                    6'h0d:   dec_exc[E_BRK]     = 1'b1;
                    default: dec_exc[E_INVALID] = 1'b1;
                endcase
            end
            6'b000001: begin
                case (rt)
                    5'b00000, 5'b00001: dec_ctrl[B_BRANCH] = 1'b1;
                    5'b10000, 5'b10001: begin
                        dec_ctrl[B_BRANCH]   = 1'b1;
                        dec_ctrl[B_REGWRITE] = 1'b1;
                        dec_ctrl[B_LINK]     = 1'b1;
                    end
                    default: dec_exc[E_INVALID] = 1'b1;
                endcase
            end
            6'b000010: dec_ctrl[B_JUMP] = 1'b1;
            6'b000011: begin
                dec_ctrl[B_JUMP]     = 1'b1;
                dec_ctrl[B_REGWRITE] = 1'b1;
                dec_ctrl[B_LINK]     = 1'b1;
            end
            6'b000100, 6'b000101, 6'b000110, 6'b000111: dec_ctrl[B_BRANCH] = 1'b1;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                dec_ctrl[B_REGWRITE] = 1'b1;
                dec_ctrl[B_ALUSRC]   = 1'b1;
            end
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
                dec_ctrl[B_REGWRITE] = 1'b1;
                dec_ctrl[B_ALUSRC]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                case (op)
                    6'b100000: begin dec_ctrl[2:1] = 2'b00; dec_ctrl[B_MEMSIGN] = 1'b1; end
                    6'b100001: begin dec_ctrl[2:1] = 2'b01; dec_ctrl[B_MEMSIGN] = 1'b1; end
                    6'b100100: dec_ctrl[2:1] = 2'b00;
                    6'b100101: dec_ctrl[2:1] = 2'b01;
                    default:   dec_ctrl[2:1] = 2'b10;
                endcase
            end
            6'b101000, 6'b101001, 6'b101011: begin
                dec_ctrl[B_ALUSRC]   = 1'b1;
                dec_ctrl[B_MEMWRITE] = 1'b1;
                case (op)
                    6'b101000: dec_ctrl[2:1] = 2'b00;
                    6'b101001: dec_ctrl[2:1] = 2'b01;
                    default:   dec_ctrl[2:1] = 2'b10;
                endcase
            end
            6'b010000: begin
                if (!ENABLE_CP0) begin
                    dec_exc[E_INVALID] = 1'b1;
                end else if (rs == 5'b00000) begin
                    dec_ctrl[B_REGWRITE] = 1'b1;
                end else if (rs == 5'b00100) begin
                    dec_ctrl[B_CP0WRITE] = 1'b1;
                end else if (rs == 5'b10000 && funct == 6'b011000) begin
                    dec_ctrl[B_ERET] = 1'b1;
                end else begin
                    dec_exc[E_INVALID] = 1'b1;
                end
            end
            default: dec_exc[E_INVALID] = 1'b1;
        endcase
    end

    logic             valid_q;
    logic [14:0]      ctrl_q;
    logic [2:0]       exc_q;
    logic [TAG_W-1:0] pc_q;
    logic             load;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            exc_q   <= '0;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            exc_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            ctrl_q  <= dec_ctrl;
            exc_q   <= dec_exc;
            pc_q    <= pc_in;
        end else if (out_ready) begin
            // drained: the bundle registers keep their contents, only valid drops
            valid_q <= 1'b0;
        end
    end

    // an empty stage must present an all-zero bundle even though ctrl_q/exc_q hold
    assign out_valid = valid_q;
    assign ctrl      = valid_q ? ctrl_q : 15'd0;
    assign exc       = valid_q ? exc_q  : 3'd0;
    assign pc_out    = pc_q;

endmodule
